uart_tx_frame_serializer: RTL and testbench
===========================================

// Module: uart_tx_frame_serializer
// PURPOSE
//  UART transmitter: accepts a parallel word, emits start, data (LSB first), optional parity and stop bits
//  on a serial line. Each bit is held for PRESCALE clocks. Transmit-side counterpart of the receive edge/bit
//  counter; shares the same prescale encoding so the two ends of one link are configured from one register.
// PARAMETERS
//  DATA_WIDTH   8   data bits per frame (1..16)
//  PS_WIDTH     6   width of prescale input / edge counter
// PORTS
//  clk          in   1           system clock, all logic on posedge
//  rst          in   1           reset, asynchronous, active-low
//  p_data       in   DATA_WIDTH  parallel word, sampled on accept
//  data_valid   in   1           request to send p_data
//  par_en       in   1           1 = parity bit inserted after data
//  par_typ      in   1           0 = even, 1 = odd parity
//  prescale     in   PS_WIDTH    clocks per bit; 0 treated as 1
//  tx_out       out  1           serial line, registered, idles high
//  busy         out  1           frame in progress, registered
//  done         out  1           one-cycle pulse on last clock of final stop bit
// BEHAVIOUR
//  Reset: state=IDLE, tx_out=1, busy=0, done=0, edge_cnt=0, bit_cnt=0, shift reg=0. Reset is asynchronous
//   mid-frame: line returns high immediately; no partial frame resumes after release.
//  FSM states: IDLE, START, DATA, PARITY, STOP.
//  Accept: in IDLE, data_valid=1 at clock edge k -> latch p_data, par_en, par_typ, prescale (0 -> 1);
//   state=START; tx_out=0 and busy=1 from cycle k+1. data_valid ignored while busy=1 (no queueing).
//  Bit timing: edge_cnt counts 1..PS_latched per bit; bit ends when edge_cnt==PS_latched, then edge_cnt=1.
//   Latched config is frozen for the whole frame; changes on inputs affect only the next frame.
//  START: tx_out=0 for PS clocks -> DATA.
//  DATA: bit_cnt 0..DATA_WIDTH-1, tx_out=data[bit_cnt] for PS clocks each; after bit DATA_WIDTH-1 ->
//   PARITY if par_en else STOP.
//  PARITY: tx_out = ^data (even) or ~^data (odd), PS clocks -> STOP.
//  STOP: tx_out=1 for PS clocks; done=1 on last clock; next state IDLE, busy=0 that same edge.
//  Back-to-back: data_valid held high re-accepts on first IDLE cycle, i.e. one IDLE clock (tx_out=1)
//   between frames at minimum.
//  Frame length (clocks, start of START to end of STOP) = PS*(1+DATA_WIDTH+par_en+N_STOP).
//  Counters never overflow: edge_cnt width PS_WIDTH, bit_cnt width clog2(DATA_WIDTH)+1.
// CONFIGURATION
//  UART_TX_TWO_STOP_EN defined: STOP lasts two bit periods (2*PS clocks, N_STOP=2); done on last clock
//   of second stop bit. Undefined: single stop bit, N_STOP=1.
// TESTING
//  1 rst low 3 cycles, release, no data_valid -> tx_out=1, busy=0, done=0 for 20 cycles.
//  2 p_data=0xA5, par_en=1, par_typ=0, PS=8 -> line 0,1,0,1,0,0,1,0,1,0,1 (start,LSB-first,par=0,stop),
//    each 8 clocks; done pulse at clock 88; busy high 88 clocks.
//  3 p_data=0x0F, par_en=1, par_typ=1, PS=4 -> parity bit 1; 0x00 odd -> parity 1; 0xFF even -> 0.
//  4 p_data=0x3C, par_en=0, PS=0 -> treated as 1: 10-clock frame, line 0,0,0,1,1,1,1,0,0,1.
//  5 second data_valid pulse mid-frame with 0xFF -> ignored, line matches first frame only; data_valid
//    held high -> frames separated by exactly one idle-high clock.
//  6 rst low during DATA bit 4 -> tx_out=1, busy=0 same cycle; after release idle until new data_valid.
//    With UART_TX_TWO_STOP_EN, case 2 -> stop held 16 clocks, done at clock 96.

Source files
------------

// File: rtl/uart_tx_frame_serializer_if.sv
// Handshake/config bundle between a UART transmit client and uart_tx_frame_serializer.
// The client drives the word and frame config; the serializer returns line, busy and done.
interface uart_tx_frame_serializer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PS_WIDTH   = 6
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_en;
    logic                  par_typ;
    logic [PS_WIDTH-1:0]   prescale;
    logic                  tx_out;
    logic                  busy;
    logic                  done;

    modport master (
        output p_data, data_valid, par_en, par_typ, prescale,
        input  tx_out, busy, done
    );

    modport slave (
        input  p_data, data_valid, par_en, par_typ, prescale,
        output tx_out, busy, done
    );
endinterface

// File: rtl/uart_tx_frame_serializer.sv
// UART transmitter: start, LSB-first data, optional parity, stop; each bit held prescale clocks.
// Define UART_TX_TWO_STOP_EN for two stop bits (default build: one stop bit).
//
// state  | meaning
// IDLE   | line high, waiting for data_valid
// START  | start bit (line low)
// DATA   | data bits, LSB first, bit_cnt selects the bit
// PARITY | parity bit computed at accept
// STOP   | stop bit(s), done on the final clock
module uart_tx_frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int PS_WIDTH   = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    uart_tx_frame_serializer_if.slave  bus
);
`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif
    localparam int BC_WIDTH = $clog2(DATA_WIDTH) + 1;
    localparam logic [BC_WIDTH-1:0] LAST_DATA = BC_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BC_WIDTH-1:0] LAST_STOP = BC_WIDTH'(N_STOP - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state_q, state_d;
    logic [PS_WIDTH-1:0]   edge_cnt_q, edge_cnt_d;
    logic [PS_WIDTH-1:0]   ps_q, ps_d;
    logic [BC_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  bit_end;

    assign bit_end = (edge_cnt_q == ps_q);

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        ps_d       = ps_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        tx_d       = tx_q;

        if (state_q == IDLE) begin
            tx_d = 1'b1;
            if (bus.data_valid) begin
                // Config is captured here and frozen until the frame ends.
                shift_d    = bus.p_data;
                par_en_d   = bus.par_en;
                par_bit_d  = bus.par_typ ? ~^bus.p_data : ^bus.p_data;
                ps_d       = (bus.prescale == '0) ? PS_WIDTH'(1) : bus.prescale;
                state_d    = START;
                edge_cnt_d = PS_WIDTH'(1);
                bit_cnt_d  = '0;
                tx_d       = 1'b0;
            end
        end else if (!bit_end) begin
            edge_cnt_d = edge_cnt_q + PS_WIDTH'(1);
        end else begin
            edge_cnt_d = PS_WIDTH'(1);
            case (state_q)
                START: begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                    tx_d      = shift_q[0];
                end
                DATA: begin
                    if (bit_cnt_q == LAST_DATA) begin
                        bit_cnt_d = '0;
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_WIDTH'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_d[0];
                    end
                end
                PARITY: begin
                    state_d   = STOP;
                    bit_cnt_d = '0;
                    tx_d      = 1'b1;
                end
                STOP: begin
                    tx_d = 1'b1;
                    if (bit_cnt_q == LAST_STOP) begin
                        state_d    = IDLE;
                        edge_cnt_d = '0;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_WIDTH'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
        // Registered done must rise on the cycle that is the final stop clock.
        done_d = (state_d == STOP) && (edge_cnt_d == ps_d) && (bit_cnt_d == LAST_STOP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            edge_cnt_q <= '0;
            ps_q       <= PS_WIDTH'(1);
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            ps_q       <= ps_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.tx_out = tx_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Directed bench for uart_tx_frame_serializer: frames, parity, prescale 0, busy-ignore, back-to-back, reset.
// Build with UART_TX_TWO_STOP_EN to expect two stop bits per frame.
module tb_uart_tx_frame_serializer;
    localparam int DW  = 8;
    localparam int PSW = 6;
`ifdef UART_TX_TWO_STOP_EN
    localparam int N_STOP = 2;
`else
    localparam int N_STOP = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass   = 0;

    uart_tx_frame_serializer_if #(.DATA_WIDTH(DW), .PS_WIDTH(PSW)) bus ();

    uart_tx_frame_serializer #(.DATA_WIDTH(DW), .PS_WIDTH(PSW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk({tag, ".tx"},   16'(bus.tx_out), 16'd1);
            chk({tag, ".busy"}, 16'(bus.busy),   16'd0);
            chk({tag, ".done"}, 16'(bus.done),   16'd0);
        end
    endtask

    task automatic accept(input logic [7:0] d, input logic pe, input logic pt,
                          input logic [5:0] ps, input logic hold);
        @(negedge clk);
        bus.p_data     = d;
        bus.par_en     = pe;
        bus.par_typ    = pt;
        bus.prescale   = ps;
        bus.data_valid = 1'b1;
        @(posedge clk);
        if (!hold) begin
            #1;
            bus.data_valid = 1'b0;
        end
    endtask

    // seq holds start/data/parity in send order, first bit at seq[n-1]; stop bits are appended here.
    task automatic check_frame(input string tag, input logic [15:0] seq, input int n,
                               input int ps, input int pulse_c);
        int len;
        int b;
        logic exp_tx;
        len = ps * (n + N_STOP);
        for (int c = 1; c <= len; c++) begin
            @(negedge clk);
            b = (c - 1) / ps;
            exp_tx = (b < n) ? seq[n-1-b] : 1'b1;
            chk({tag, ".tx"},   16'(bus.tx_out), 16'(exp_tx));
            chk({tag, ".busy"}, 16'(bus.busy),   16'd1);
            chk({tag, ".done"}, 16'(bus.done),   16'(c == len));
            if (c == pulse_c) begin
                bus.p_data     = 8'hFF;
                bus.data_valid = 1'b1;
            end
            if (c == pulse_c + 1) bus.data_valid = 1'b0;
        end
    endtask

    initial begin
        bus.p_data     = '0;
        bus.data_valid = 1'b0;
        bus.par_en     = 1'b0;
        bus.par_typ    = 1'b0;
        bus.prescale   = '0;

        // reset state, then quiet idle line
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.tx",   16'(bus.tx_out), 16'd1);
        chk("rst.busy", 16'(bus.busy),   16'd0);
        chk("rst.done", 16'(bus.done),   16'd0);
        rst = 1'b1;
        check_idle("t1", 20);

        // 0xA5 even parity, PS=8
        accept(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
        check_frame("t2", 16'b0_10100101_0, 10, 8, -1);
        check_idle("t2.after", 2);

        // parity variants
        accept(8'h0F, 1'b1, 1'b1, 6'd4, 1'b0);
        check_frame("t3a", 16'b0_11110000_1, 10, 4, -1);
        check_idle("t3a.after", 1);
        accept(8'h00, 1'b1, 1'b1, 6'd2, 1'b0);
        check_frame("t3b", 16'b0_00000000_1, 10, 2, -1);
        check_idle("t3b.after", 1);
        accept(8'hFF, 1'b1, 1'b0, 6'd2, 1'b0);
        check_frame("t3c", 16'b0_11111111_0, 10, 2, -1);
        check_idle("t3c.after", 1);

        // prescale 0 behaves as 1, no parity
        accept(8'h3C, 1'b0, 1'b0, 6'd0, 1'b0);
        check_frame("t4", 16'b0_00111100, 9, 1, -1);
        check_idle("t4.after", 2);

        // data_valid pulse while busy is dropped
        accept(8'h3C, 1'b0, 1'b0, 6'd2, 1'b0);
        check_frame("t5a", 16'b0_00111100, 9, 2, 5);
        check_idle("t5a.after", 4);

        // held data_valid: exactly one idle clock between frames
        accept(8'h0F, 1'b1, 1'b0, 6'd2, 1'b1);
        check_frame("t5b1", 16'b0_11110000_0, 10, 2, -1);
        @(negedge clk);
        chk("t5b.gap.tx",   16'(bus.tx_out), 16'd1);
        chk("t5b.gap.busy", 16'(bus.busy),   16'd0);
        bus.p_data = 8'hA5;
        bus.par_en = 1'b0;
        @(posedge clk);
        #1;
        bus.data_valid = 1'b0;
        check_frame("t5b2", 16'b0_10100101, 9, 2, -1);
        check_idle("t5b.after", 3);

        // async reset during data bit 4 (cycles 41..48 at PS=8)
        accept(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
        repeat (42) @(negedge clk);
        chk("t6.pre.tx",   16'(bus.tx_out), 16'd0);
        chk("t6.pre.busy", 16'(bus.busy),   16'd1);
        rst = 1'b0;
        #1;
        chk("t6.rst.tx",   16'(bus.tx_out), 16'd1);
        chk("t6.rst.busy", 16'(bus.busy),   16'd0);
        chk("t6.rst.done", 16'(bus.done),   16'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        check_idle("t6.idle", 12);
        accept(8'h3C, 1'b0, 1'b0, 6'd1, 1'b0);
        check_frame("t6.new", 16'b0_00111100, 9, 1, -1);
        check_idle("t6.after", 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
